// File: rtl/prim_reqack_pkg.sv
// Shared types for the REQ/ACK initiator and watchdog.
// Keeps the initiator FSM encoding in one place for both sides of the link.
package prim_reqack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2
  } reqack_init_state_e;

  // REQ is held in every state except IDLE.
  function automatic logic state_drives_req(reqack_init_state_e st);
    return st != IDLE;
  endfunction

endpackage

// File: rtl/prim_reqack_initiator_if.sv
// Handshake and status bundle between the initiator and its event source / synchronizer.
interface prim_reqack_initiator_if #(
  parameter int unsigned CntWidth = 4
);

  logic                event_i;
  logic                req_o;
  logic                ack_i;
  logic [CntWidth-1:0] pending_o;
  logic                busy_o;
  logic                overflow_o;
  logic                timeout_o;
  logic                err_o;

  modport master (
    input  event_i,
    input  ack_i,
    output req_o,
    output pending_o,
    output busy_o,
    output overflow_o,
    output timeout_o,
    output err_o
  );

  modport slave (
    output event_i,
    output ack_i,
    input  req_o,
    input  pending_o,
    input  busy_o,
    input  overflow_o,
    input  timeout_o,
    input  err_o
  );

endinterface

// File: rtl/prim_reqack_wdog.sv
// Up-counting watchdog with clear/enable and a one-cycle expire strobe.
// TimeoutCycles == 0 disables it: the counter stays at zero and never expires.
module prim_reqack_wdog #(
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned TimerWidth    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam bit          Enabled = (TimeoutCycles != 0);
  localparam int unsigned LastInt = Enabled ? TimeoutCycles - 1 : 0;
  localparam logic [TimerWidth-1:0] Last = TimerWidth'(LastInt);

  logic [TimerWidth-1:0] timer_q;
  logic                  run;

  assign run = Enabled && en_i && !clr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else if (clr_i) begin
      timer_q <= '0;
    end else if (run) begin
      timer_q <= timer_q + TimerWidth'(1);
    end
  end

  // Fires on the last counted cycle so the caller can register the pulse.
  assign expire_o = run && (timer_q == Last);

endmodule

// File: rtl/prim_reqack_initiator.sv
// SRC-side initiator: converts event pulses into two-phase REQ/ACK handshakes,
// coalescing pending events in a saturating counter and watching for a stalled partner.
module prim_reqack_initiator
  import prim_reqack_pkg::*;
#(
  parameter int unsigned CntWidth      = 4,
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned TimerWidth    = 16,
  // Clear where the partner may legitimately raise ACK with REQ low.
  parameter bit          ChkAckIdle    = 1'b1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  prim_reqack_initiator_if.master bus
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  reqack_init_state_e state_q, state_d;
  logic [CntWidth-1:0] pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                to_q;
  logic                err_q;
  logic                req;
  logic                hs;
  logic                full;
  logic                wd_clr;
  logic                wd_en;
  logic                wd_expire;

  assign req  = state_drives_req(state_q);
  assign hs   = req && bus.ack_i;
  assign full = (pend_q == CntMax);

  // Pending-event counter: an event and a handshake in the same cycle cancel.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (bus.event_i && !hs) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + CntWidth'(1);
      end
    end else if (!bus.event_i && hs) begin
      pend_d = pend_q - CntWidth'(1);
    end
  end

  // Every handshake starts a fresh REQ phase for the watchdog.
  assign wd_clr = (state_q == IDLE) || hs;
  assign wd_en  = (state_q == WAIT) && !hs;

  prim_reqack_wdog #(
    .TimeoutCycles (TimeoutCycles),
    .TimerWidth    (TimerWidth)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pend_d != '0) state_d = WAIT;
      end
      WAIT: begin
        if (pend_d == '0) begin
          state_d = IDLE;
        end else if (wd_expire) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (hs) state_d = (pend_d == '0) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      to_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      to_q   <= wd_expire;
      err_q  <= err_q || wd_expire;
    end
  end

  assign bus.req_o      = req;
  assign bus.pending_o  = pend_q;
  assign bus.busy_o     = (pend_q != '0);
  assign bus.overflow_o = ovf_q;
  assign bus.timeout_o  = to_q;
  assign bus.err_o      = err_q;

  a_req_falls_on_hs : assert property (@(posedge clk_i)
    $fell(bus.req_o) |-> ($past(bus.req_o && bus.ack_i) || $past(rst_i)));

  a_ovf_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.overflow_o |-> $past(pend_q == CntMax));

  if (ChkAckIdle) begin : g_ack_chk
    a_ack_needs_req : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.ack_i |-> bus.req_o);
  end

endmodule

// File: tb/tb_prim_reqack_initiator.sv
// Bench for prim_reqack_initiator: event-count reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_prim_reqack_initiator;

  localparam int CW   = 2;
  localparam int TO   = 8;
  localparam int MAXP = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  prim_reqack_initiator_if #(.CntWidth(CW)) bus ();

  prim_reqack_initiator #(
    .CntWidth      (CW),
    .TimeoutCycles (TO),
    .TimerWidth    (8),
    .ChkAckIdle    (1'b0)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int hs_cnt      = 0;
  int acc_cnt     = 0;

  int m_pend = 0;
  int m_wait = 0;
  bit m_req  = 1'b0;
  bit m_ovf  = 1'b0;
  bit m_to   = 1'b0;
  bit m_err  = 1'b0;
  bit started = 1'b0;

  // Reference: pending = accepted - handshaked; REQ mirrors pending != 0 one cycle late;
  // timeout when REQ has been high TO cycles since the last handshake or rise.
  always @(posedge clk_i) begin : model
    bit hs, acc;
    if (rst_i) begin
      m_pend = 0; m_wait = 0; m_req = 0; m_ovf = 0; m_to = 0; m_err = 0;
    end else begin
      hs  = m_req && bus.ack_i;
      acc = bus.event_i && !(m_pend == MAXP && !hs);
      m_ovf  = bus.event_i && !acc;
      m_pend = m_pend + int'(acc) - int'(hs);
      if (hs || !m_req) m_wait = 0;
      else m_wait = m_wait + 1;
      m_to  = (m_wait == TO);
      m_err = m_err || m_to;
      m_req = (m_pend != 0);
      if (acc) acc_cnt++;
    end
    started = 1'b1;
  end

  always @(posedge clk_i) begin
    if (!rst_i && bus.req_o && bus.ack_i) hs_cnt++;
  end

  always @(negedge clk_i) begin
    if (started) begin
      vectors++;
      if (int'(bus.pending_o) != m_pend || bus.req_o !== m_req || bus.busy_o !== (m_pend != 0) ||
          bus.overflow_o !== m_ovf || bus.timeout_o !== m_to || bus.err_o !== m_err) begin
        miscompares++;
        $display("FAIL model t=%0t got pend=%0d req=%0b busy=%0b ovf=%0b to=%0b err=%0b expected pend=%0d req=%0b busy=%0b ovf=%0b to=%0b err=%0b",
                 $time, bus.pending_o, bus.req_o, bus.busy_o, bus.overflow_o, bus.timeout_o, bus.err_o,
                 m_pend, m_req, (m_pend != 0), m_ovf, m_to, m_err);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit ev, input bit ack);
    bus.event_i = ev;
    bus.ack_i   = ack;
    @(negedge clk_i);
  endtask

  initial begin
    int h0, a0;
    bus.event_i = 1'b0;
    bus.ack_i   = 1'b0;
    rst_i       = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset_req", bus.req_o, 0);
    chk("reset_pending", bus.pending_o, 0);
    chk("reset_err", bus.err_o, 0);
    rst_i = 1'b0;

    // Single event, ACK on the third REQ-high cycle.
    cyc(1, 0);
    chk("single_req_rise", bus.req_o, 1);
    chk("single_pending", bus.pending_o, 1);
    cyc(0, 0);
    cyc(0, 0);
    chk("single_req_hold", bus.req_o, 1);
    cyc(0, 1);
    chk("single_req_fall", bus.req_o, 0);
    chk("single_busy_fall", bus.busy_o, 0);

    // Five back-to-back events with ACK tied high.
    h0 = hs_cnt;
    repeat (5) cyc(1, 1);
    chk("b2b_req_cont", bus.req_o, 1);
    chk("b2b_pending", bus.pending_o, 1);
    cyc(0, 1);
    chk("b2b_hs_count", hs_cnt - h0, 5);
    chk("b2b_req_fall", bus.req_o, 0);
    cyc(0, 0);

    // Saturation and overflow at pending == 3.
    repeat (3) cyc(1, 0);
    chk("sat_pending", bus.pending_o, 3);
    cyc(1, 0);
    chk("ovf_pulse", bus.overflow_o, 1);
    chk("ovf_pending", bus.pending_o, 3);
    cyc(1, 1);
    chk("full_ev_hs_pending", bus.pending_o, 3);
    chk("full_ev_hs_no_ovf", bus.overflow_o, 0);
    repeat (3) cyc(0, 1);
    chk("drain_pending", bus.pending_o, 0);

    // Watchdog: timeout pulse 8 cycles after REQ rises.
    cyc(1, 0);
    repeat (7) cyc(0, 0);
    chk("to_early", bus.timeout_o, 0);
    cyc(0, 0);
    chk("to_pulse", bus.timeout_o, 1);
    chk("to_err", bus.err_o, 1);
    chk("to_req_held", bus.req_o, 1);
    cyc(0, 0);
    chk("to_single", bus.timeout_o, 0);
    chk("err_sticky", bus.err_o, 1);
    cyc(0, 1);
    chk("late_ack_req", bus.req_o, 0);
    chk("late_ack_err", bus.err_o, 1);

    // Reset with two events pending, then ACK while REQ is low.
    cyc(1, 0);
    cyc(1, 0);
    chk("pre_rst_pending", bus.pending_o, 2);
    rst_i = 1'b1;
    cyc(0, 0);
    chk("rst_outputs", {bus.req_o, bus.busy_o, bus.overflow_o, bus.timeout_o, bus.err_o, bus.pending_o}, 0);
    rst_i = 1'b0;
    cyc(0, 1);
    chk("idle_ack_req", bus.req_o, 0);
    chk("idle_ack_pending", bus.pending_o, 0);

    // Random traffic: a busy partner, then a sluggish one to hit overflow and timeouts.
    a0 = acc_cnt;
    h0 = hs_cnt;
    repeat (400) cyc($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 60);
    repeat (300) cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8);
    for (int i = 0; i < 20 && bus.req_o; i++) cyc(0, 1);
    chk("rand_drained", bus.req_o, 0);
    chk("rand_hs_eq_acc", hs_cnt - h0, acc_cnt - a0);
    cyc(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
